booth_seq_multiplier: RTL and testbench

Parametrised radix-2 Booth sequential multiplier with valid/ready handshakes on both operand and result sides, and a per-operation signed/unsigned select. It is the successor to the fixed 32-bit free-running sequential multiplier. It adds:
- explicit operation boundaries instead of free-running,
- result backpressure,
- unsigned mode,
- back-to-back acceptance.

It sits between an operand producer and a result consumer in the multiplier datapath.

---
 rtl/mult_pkg.sv | 14 +
 rtl/booth_step.sv | 31 +++
 rtl/booth_seq_multiplier.sv | 97 +++++++++
 tb/tb_booth_seq_multiplier.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth sequential multiplier: FSM state encodings
// and the Booth pair codes that select add or subtract.
package mult_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the {acc, Q, q-1} register: optional add or
// subtract of the multiplicand into acc, then an arithmetic right shift.
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH+2:0] work,
    input  logic [WIDTH:0]     mcand,
    output logic [2*WIDTH+2:0] work_next
);

    logic [WIDTH:0] acc;
    logic [WIDTH:0] q;
    logic           q_minus1;
    logic [WIDTH:0] sum;

    // acc never exceeds |mcand| before the shift, so WIDTH+1 bits cannot overflow
    always_comb begin
        acc      = work[2*WIDTH+2:WIDTH+2];
        q        = work[WIDTH+1:1];
        q_minus1 = work[0];
        case ({q[0], q_minus1})
            BOOTH_ADD: sum = acc + mcand;
            BOOTH_SUB: sum = acc - mcand;
            default:   sum = acc;
        endcase
        work_next = {sum[WIDTH], sum, q};
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Radix-2 Booth sequential multiplier with valid/ready handshakes on operands
// and result, per-operation signed/unsigned select and back-to-back acceptance.
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH);

    mult_state_t        state;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     mcand;
    logic [2*WIDTH+2:0] work;
    logic [2*WIDTH+2:0] work_next;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic               accept;

    // One extra bit lets unsigned operands ride the same signed Booth datapath
    assign a_ext = {is_signed & a[WIDTH-1], a};
    assign b_ext = {is_signed & b[WIDTH-1], b};

    // out_ready feeds in_ready combinationally so DONE can hand off in one cycle
    assign in_ready = (state == MULT_IDLE) || ((state == MULT_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .work      (work),
        .mcand     (mcand),
        .work_next (work_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MULT_IDLE;
            count     <= '0;
            mcand     <= '0;
            work      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= MULT_RUN;
            count     <= '0;
            mcand     <= a_ext;
            work      <= {{(WIDTH+1){1'b0}}, b_ext, 1'b0};
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                MULT_RUN: begin
                    work  <= work_next;
                    count <= count + CW'(1);
                    // Low 2*WIDTH bits of {acc,Q} are exact in both modes
                    if (count == LAST_ITER) begin
                        result    <= work_next[2*WIDTH:1];
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= MULT_DONE;
                    end
                end
                MULT_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= MULT_IDLE;
                    end
                end
                default: state <= MULT_IDLE;
            endcase
        end
    end

    // A held result must not move while the consumer stalls
    assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(result)));

    assert property (@(posedge clk) disable iff (reset)
        !(out_valid && busy));

    assert property (@(posedge clk) disable iff (reset)
        busy == (state == MULT_RUN));

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier at WIDTH=32: expected products are
// queued at operand acceptance and compared when the result handshake occurs.
module tb_booth_seq_multiplier;

    localparam int WIDTH = 32;

    typedef struct {
        logic [63:0] expected;
        int          accept_cycle;
    } sb_entry_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              is_signed = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [2*WIDTH-1:0] result;
    logic              busy;

    sb_entry_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int last_accept = 0;
    logic prev_valid = 1'b0;

    booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        return xe * ye;
    endfunction

    // Presents operands (called at posedge+#1) and returns just after the accept edge.
    // in_valid is left high; the caller decides whether to keep streaming.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic [63:0] expected);
        bit accepted;
        sb_entry_t entry;
        accepted = 0;
        a = x;
        b = y;
        is_signed = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("acceptTimeout", 64'd1, 64'd0);
            in_valid = 1'b0;
            last_accept = -1;
            return;
        end
        @(posedge clk);
        #1;
        last_accept = cycle;
        entry.expected = expected;
        entry.accept_cycle = cycle;
        sb.push_back(entry);
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                drained = 1;
                break;
            end
        end
        if (!drained) checkOutput("drainTimeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Result monitor: latency and busy on each rising out_valid, value on handshake
    always @(negedge clk) begin
        sb_entry_t entry;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedValid", 64'd1, 64'd0);
                end else begin
                    checkOutput("latency", 64'(cycle - sb[0].accept_cycle), 64'(WIDTH + 1));
                    checkOutput("busyWithValid", 64'(busy), 64'd0);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                entry = sb.pop_front();
                checkOutput("result", result, entry.expected);
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int t0;
        int t1;
        int release_cycle;
        logic [31:0] x;
        logic [31:0] y;
        logic s;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetInReady", 64'(in_ready), 64'd1);
        checkOutput("resetOutValid", 64'(out_valid), 64'd0);
        checkOutput("resetBusy", 64'(busy), 64'd0);
        checkOutput("resetResult", result, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned single operation
        out_ready = 1'b1;
        applyStimulus(32'd35, 32'd96, 1'b0, 64'd3360);
        in_valid = 1'b0;
        waitDrain();

        // Signed back-to-back with in_valid held
        applyStimulus(-32'sd15, 32'd20, 1'b1, -64'sd300);
        t0 = last_accept;
        applyStimulus(-32'sd17, -32'sd17, 1'b1, 64'd289);
        t1 = last_accept;
        checkOutput("spacing1", 64'(t1 - t0), 64'd34);
        applyStimulus(32'd0, 32'd64, 1'b1, 64'd0);
        checkOutput("spacing2", 64'(last_accept - t1), 64'd34);
        in_valid = 1'b0;
        waitDrain();

        // Extreme operands
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        in_valid = 1'b0;
        waitDrain();
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        in_valid = 1'b0;
        waitDrain();
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        in_valid = 1'b0;
        waitDrain();

        // Backpressure
        out_ready = 1'b0;
        applyStimulus(32'd3672, 32'd9648, 1'b0, 64'd35427456);
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) checkOutput("validTimeout", 64'd1, 64'd0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bpResult", result, 64'd35427456);
            checkOutput("bpInReady", 64'(in_ready), 64'd0);
            checkOutput("bpOutValid", 64'(out_valid), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("idleOutValid", 64'(out_valid), 64'd0);
        checkOutput("idleInReady", 64'(in_ready), 64'd1);
        checkOutput("idleBusy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-operation
        out_ready = 1'b1;
        applyStimulus(32'd165, 32'd348, 1'b0, 64'd57420);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        #1;
        checkOutput("rstInReady", 64'(in_ready), 64'd1);
        checkOutput("rstResult", result, 64'd0);
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        release_cycle = cycle;
        applyStimulus(32'd36, 32'd42, 1'b0, 64'd1512);
        checkOutput("firstAccept", 64'(last_accept - release_cycle), 64'd1);
        in_valid = 1'b0;
        waitDrain();

        // Operand churn during RUN must not disturb the captured operands
        for (int k = 0; k < 4; k++) begin
            x = $urandom;
            y = $urandom;
            s = k[0];
            applyStimulus(x, y, s, model(x, y, s));
            in_valid = 1'b0;
            repeat (WIDTH + 1) begin
                a = $urandom;
                b = $urandom;
                is_signed = $urandom_range(0, 1);
                @(posedge clk);
                #1;
            end
            waitDrain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
